// File: rtl/sda_kernel_ctrl_regfile_if.sv
// AXI4-Lite control bus for the kernel control register file.
// The signal names follow the s_axi_control_* port names.
interface sda_kernel_ctrl_regfile_if #(
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [31:0]           RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/sda_kernel_ctrl_regfile.sv
// Kernel control register file: ap_ctrl start/done/idle/ready, auto-restart,
// GIE/IER/ISR interrupt and scalar argument registers behind AXI4-Lite.
module sda_kernel_ctrl_regfile #(
    parameter int AXI_SLAVE_ADDR_WIDTH = 6,
    parameter int NUM_ARGS             = 4,
    parameter bit AUTO_RESTART_EN      = 1'b1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    sda_kernel_ctrl_regfile_if.slave  s_axi_control,
    output logic                      action_go_valid,
    input  logic                      action_go_holdoff,
    input  logic                      action_done_valid,
    output logic                      action_done_stop,
    output logic [32*NUM_ARGS-1:0]    arg_data,
    output logic                      interrupt
);
    localparam int WORD_W = AXI_SLAVE_ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] A_CTRL = WORD_W'(0);
    localparam logic [WORD_W-1:0] A_GIE  = WORD_W'(1);
    localparam logic [WORD_W-1:0] A_IER  = WORD_W'(2);
    localparam logic [WORD_W-1:0] A_ISR  = WORD_W'(3);
    localparam int                ARG_BASE = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_GO, ST_RUN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_start;
    logic              r_done;
    logic              r_ready;
    logic              r_auto_restart;
    logic              r_gie;
    logic [1:0]        r_ier;
    logic [1:0]        r_isr;
    logic              r_bvalid;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [31:0]       w_rd_data;
    logic [31:0]       w_arg [NUM_ARGS];
    logic [WORD_W-1:0] w_wr_word;
    logic [WORD_W-1:0] w_rd_word;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_wr_ctrl;
    logic              w_go_hs;
    logic              w_done_acc;
    logic              w_idle;
    logic [1:0]        w_isr_evt;
    logic [1:0]        w_isr_tgl;
    logic              w_unused;

    assign w_wr_word  = s_axi_control.AWADDR[AXI_SLAVE_ADDR_WIDTH-1:2];
    assign w_rd_word  = s_axi_control.ARADDR[AXI_SLAVE_ADDR_WIDTH-1:2];
    assign w_wr_fire  = s_axi_control.AWVALID & s_axi_control.WVALID & ~r_bvalid;
    assign w_rd_fire  = s_axi_control.ARVALID & ~r_rvalid;
    assign w_wr_ctrl  = w_wr_fire && (w_wr_word == A_CTRL) && s_axi_control.WSTRB[0];
    assign w_go_hs    = (r_state == ST_GO) && !action_go_holdoff;
    assign w_done_acc = (r_state == ST_RUN) && action_done_valid;
    assign w_unused   = &{1'b0, s_axi_control.AWADDR[1:0], s_axi_control.ARADDR[1:0]};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (r_start) w_state_next = ST_GO;
            ST_GO:   if (w_go_hs) w_state_next = ST_RUN;
            ST_RUN:  if (w_done_acc) w_state_next = r_auto_restart ? ST_GO : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        action_go_valid  = (r_state == ST_GO);
        action_done_stop = (r_state != ST_RUN);
        w_idle           = (r_state == ST_IDLE);
    end

    // Start is only writable while idle; without auto-restart it drops at the go
    // handshake, and a run that loses auto-restart midway also clears it so the
    // core really settles in IDLE after its final done.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_start        <= 1'b0;
            r_done         <= 1'b0;
            r_ready        <= 1'b0;
            r_auto_restart <= 1'b0;
            r_gie          <= 1'b0;
            r_ier          <= 2'b00;
            r_isr          <= 2'b00;
        end else begin
            if (w_wr_ctrl && (r_state == ST_IDLE)) begin
                r_start <= s_axi_control.WDATA[0];
            end else if ((w_go_hs || w_done_acc) && !r_auto_restart) begin
                r_start <= 1'b0;
            end
            if (w_wr_ctrl && AUTO_RESTART_EN) begin
                r_auto_restart <= s_axi_control.WDATA[7];
            end
            if (w_done_acc) begin
                r_done <= 1'b1;
            end else if (w_rd_fire && (w_rd_word == A_CTRL)) begin
                r_done <= 1'b0;
            end
            r_ready <= w_go_hs;
            if (w_wr_fire && (w_wr_word == A_GIE) && s_axi_control.WSTRB[0]) begin
                r_gie <= s_axi_control.WDATA[0];
            end
            if (w_wr_fire && (w_wr_word == A_IER) && s_axi_control.WSTRB[0]) begin
                r_ier <= s_axi_control.WDATA[1:0];
            end
            r_isr <= w_isr_evt | (r_isr ^ w_isr_tgl);
        end
    end

    assign w_isr_evt = {w_go_hs & r_ier[1], w_done_acc & r_ier[0]};
    assign w_isr_tgl = (w_wr_fire && (w_wr_word == A_ISR) && s_axi_control.WSTRB[0])
                       ? s_axi_control.WDATA[1:0] : 2'b00;
    assign interrupt = r_gie & |(r_isr & r_ier);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ARGS; gi++) begin : gen_arg
            logic [31:0] r_arg;
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    r_arg <= '0;
                end else if (w_wr_fire && (w_wr_word == WORD_W'(ARG_BASE + gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_axi_control.WSTRB[b]) begin
                            r_arg[8*b +: 8] <= s_axi_control.WDATA[8*b +: 8];
                        end
                    end
                end
            end
            assign w_arg[gi]             = r_arg;
            assign arg_data[32*gi +: 32] = r_arg;
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        case (w_rd_word)
            A_CTRL:  w_rd_data = {24'b0, r_auto_restart, 3'b000, r_ready, w_idle, r_done, r_start};
            A_GIE:   w_rd_data = {31'b0, r_gie};
            A_IER:   w_rd_data = {30'b0, r_ier};
            A_ISR:   w_rd_data = {30'b0, r_isr};
            default: begin
                for (int i = 0; i < NUM_ARGS; i++) begin
                    if (w_rd_word == WORD_W'(ARG_BASE + i)) w_rd_data = w_arg[i];
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
            end else if (s_axi_control.BREADY) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (s_axi_control.RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi_control.AWREADY = w_wr_fire;
    assign s_axi_control.WREADY  = w_wr_fire;
    assign s_axi_control.BRESP   = 2'b00;
    assign s_axi_control.BVALID  = r_bvalid;
    assign s_axi_control.ARREADY = ~r_rvalid;
    assign s_axi_control.RDATA   = r_rdata;
    assign s_axi_control.RRESP   = 2'b00;
    assign s_axi_control.RVALID  = r_rvalid;
endmodule

// File: tb/tb_sda_kernel_ctrl_regfile.sv
// Scoreboard bench for sda_kernel_ctrl_regfile: reads push expected data,
// a negedge monitor pops and compares whenever RVALID is presented.
module tb_sda_kernel_ctrl_regfile;
    localparam int AW = 6;
    localparam int NA = 4;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    sda_kernel_ctrl_regfile_if #(.ADDR_WIDTH(AW)) axi ();
    logic            action_go_valid;
    logic            action_go_holdoff;
    logic            action_done_valid;
    logic            action_done_stop;
    logic [32*NA-1:0] arg_data;
    logic            interrupt;

    sda_kernel_ctrl_regfile #(
        .AXI_SLAVE_ADDR_WIDTH(AW),
        .NUM_ARGS(NA),
        .AUTO_RESTART_EN(1'b1)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .s_axi_control(axi),
        .action_go_valid(action_go_valid),
        .action_go_holdoff(action_go_holdoff),
        .action_done_valid(action_done_valid),
        .action_done_stop(action_done_stop),
        .arg_data(arg_data),
        .interrupt(interrupt)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    int go_cycles = 0;
    int go_hs = 0;
    int idle_cycles = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", nm, act);
        end
    endtask

    // Read-response monitor
    always @(negedge ap_clk) begin
        if (axi.RVALID && axi.RREADY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%08h expected no response", axi.RDATA);
            end else begin
                check(name_q.pop_front(), axi.RDATA, exp_q.pop_front());
            end
        end
    end

    always @(negedge ap_clk) begin
        if (action_go_valid) go_cycles++;
        if (action_go_valid && !action_go_holdoff) go_hs++;
        if (action_done_stop && !action_go_valid) idle_cycles++;
    end

    task automatic sync();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        axi.AWADDR = a; axi.WDATA = d; axi.WSTRB = s;
        axi.AWVALID = 1'b1; axi.WVALID = 1'b1;
        @(negedge ap_clk);
        while (!axi.AWREADY && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        if (!axi.AWREADY) begin
            checks++; errors++;
            $display("FAIL wr_timeout: addr 0x%02h got no AWREADY required AWREADY=1", a);
        end
        sync();
        axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
        if (axi.BREADY) sync();
        $display("wr   addr 0x%02h data 0x%08h strb 0x%h", a, d, s);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] e, input string nm);
        int n = 0;
        exp_q.push_back(e);
        name_q.push_back(nm);
        axi.ARADDR = a; axi.ARVALID = 1'b1;
        @(negedge ap_clk);
        while (!axi.ARREADY && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        if (!axi.ARREADY) begin
            checks++; errors++;
            $display("FAIL rd_timeout %s: got no ARREADY required ARREADY=1", nm);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        sync();
        axi.ARVALID = 1'b0;
        sync();
    endtask

    task automatic wait_run();
        int n = 0;
        @(negedge ap_clk);
        while (action_done_stop && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        if (action_done_stop) begin
            checks++; errors++;
            $display("FAIL run_timeout: done_stop got 1 required 0");
        end
        sync();
    endtask

    task automatic pulse_done();
        action_done_valid = 1'b1;
        sync();
        action_done_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        axi.AWADDR = '0; axi.AWVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 1'b0;
        axi.BREADY = 1'b1; axi.ARADDR = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b1;
        action_go_holdoff = 1'b0;
        action_done_valid = 1'b0;

        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_go_valid", 32'(action_go_valid), 32'd0);
        check("rst_done_stop", 32'(action_done_stop), 32'd1);
        check("rst_interrupt", 32'(interrupt), 32'd0);
        check("rst_bvalid", 32'(axi.BVALID), 32'd0);
        sync();
        ap_rst_n = 1'b1;
        sync();
        axi_read(6'h00, 32'h0000_0004, "rst_ctrl");

        // 1: argument register with byte strobes
        axi_write(6'h14, 32'hDEAD_BEEF, 4'hF);
        axi_write(6'h14, 32'h0000_1100, 4'h2);
        axi_read(6'h14, 32'hDEAD_11EF, "arg1_rd");
        @(negedge ap_clk);
        check("arg1_port", arg_data[63:32], 32'hDEAD_11EF);
        check("arg0_port", arg_data[31:0], 32'h0000_0000);
        sync();

        // 2: go held off for three cycles
        action_go_holdoff = 1'b1;
        base = go_cycles;
        axi_write(6'h00, 32'h0000_0001, 4'h1);
        n = 0;
        @(negedge ap_clk);
        while (!action_go_valid && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        if (!action_go_valid) begin
            checks++; errors++;
            $display("FAIL go_timeout: go_valid got 0 required 1");
        end
        sync();
        axi.ARADDR = 6'h00; axi.ARVALID = 1'b1;
        exp_q.push_back(32'h0000_0001); name_q.push_back("go_start_rd");
        sync();
        axi.ARVALID = 1'b0;
        sync();
        action_go_holdoff = 1'b0;
        wait_run();
        check("go_valid_cycles", 32'(go_cycles - base), 32'd4);
        pulse_done();
        axi_read(6'h00, 32'h0000_0006, "ctrl_done");
        axi_read(6'h00, 32'h0000_0004, "ctrl_done_clr");

        // 3: done interrupt
        axi_write(6'h04, 32'h1, 4'hF);
        axi_write(6'h08, 32'h1, 4'hF);
        axi_write(6'h00, 32'h1, 4'h1);
        wait_run();
        action_done_valid = 1'b1;
        @(negedge ap_clk);
        check("irq_pre", 32'(interrupt), 32'd0);
        sync();
        action_done_valid = 1'b0;
        @(negedge ap_clk);
        check("irq_after_done", 32'(interrupt), 32'd1);
        sync();
        axi_write(6'h0C, 32'h1, 4'hF);
        @(negedge ap_clk);
        check("irq_cleared", 32'(interrupt), 32'd0);
        sync();
        axi_read(6'h0C, 32'h0, "isr_clr");
        axi_read(6'h00, 32'h0000_0006, "ctrl_done_irq");

        // 4: auto-restart: initial go plus one restart per done
        base = go_hs;
        axi_write(6'h00, 32'h0000_0081, 4'h1);
        wait_run();
        n = idle_cycles;
        axi_read(6'h00, 32'h0000_0081, "ar_ctrl");
        repeat (3) begin
            pulse_done();
            wait_run();
        end
        check("ar_go_hs", 32'(go_hs - base), 32'd4);
        check("ar_idle_cycles", 32'(idle_cycles - n), 32'd0);
        axi_write(6'h00, 32'h0, 4'h1);
        pulse_done();
        repeat (3) sync();
        @(negedge ap_clk);
        check("ar_stop_go", 32'(action_go_valid), 32'd0);
        check("ar_stop_done_stop", 32'(action_done_stop), 32'd1);
        sync();
        axi_read(6'h00, 32'h0000_0006, "ar_idle_ctrl");

        // 5: done accept races a CTRL read
        axi_write(6'h00, 32'h1, 4'h1);
        wait_run();
        axi.ARADDR = 6'h00; axi.ARVALID = 1'b1; action_done_valid = 1'b1;
        exp_q.push_back(32'h0000_0000); name_q.push_back("race_rd");
        sync();
        axi.ARVALID = 1'b0; action_done_valid = 1'b0;
        sync();
        axi_read(6'h00, 32'h0000_0006, "race_next_rd");

        // 6: reset mid-run with a pending write response
        axi_write(6'h08, 32'h3, 4'hF);
        axi_write(6'h00, 32'h1, 4'h1);
        wait_run();
        @(negedge ap_clk);
        check("irq_ready", 32'(interrupt), 32'd1);
        sync();
        axi.BREADY = 1'b0;
        axi_write(6'h10, 32'h1234_5678, 4'hF);
        @(negedge ap_clk);
        check("bvalid_hold", 32'(axi.BVALID), 32'd1);
        check("arg0_written", arg_data[31:0], 32'h1234_5678);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("arst_bvalid", 32'(axi.BVALID), 32'd0);
        check("arst_done_stop", 32'(action_done_stop), 32'd1);
        check("arst_go_valid", 32'(action_go_valid), 32'd0);
        check("arst_interrupt", 32'(interrupt), 32'd0);
        check("arst_arg0", arg_data[31:0], 32'h0);
        sync();
        sync();
        axi.BREADY = 1'b1;
        ap_rst_n = 1'b1;
        sync();
        axi_read(6'h3C, 32'h0, "unmapped_rd");
        axi_read(6'h04, 32'h0, "gie_after_rst");
        axi_read(6'h00, 32'h0000_0004, "ctrl_after_rst");

        repeat (3) sync();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
